pipe_mem_memwb: RTL
===================

PIPE_MEM_MEMWB -- requirements
Module: pipe_mem_memwb

Interface
REQ-001 Parameter: TIMEOUT, 255, number of WAIT cycles without mem_ack before a bus error (1..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, synchronous and active-low (0 = reset, sampled on rising clk).
REQ-004 EXMEM  input  73  EX/MEM register: [72] MemRead, [71] MemWrite, [70] RegWrite, [69] MemtoReg, [68:64] rd, [63:32] store data, [31:0] ALU result / address.
REQ-005 MEMWB  output  71  MEM/WB register: [70] RegWrite, [69] MemtoReg, [68:64] rd, [63:32] load data, [31:0] ALU result.
REQ-006 dataEXMEM  output  32  forwarding value, combinational EXMEM[31:0].
REQ-007 dataMEMWB  output  32  forwarding value, combinational: MEMWB[69] ? MEMWB[63:32] : MEMWB[31:0].
REQ-008 MemStall  output  1  combinational; 1 = upstream holds EXMEM and freezes earlier stages.
REQ-009 AlignErr  output  1  registered one-cycle pulse: misaligned access dropped.
REQ-010 BusErr  output  1  registered one-cycle pulse: memory timeout.
REQ-011 mem_req, mem_we  output  1 each  registered request and write-enable to data memory.
REQ-012 mem_addr, mem_wdata  output  32 each  registered address and store data.
REQ-013 mem_rdata  input  32  load data, valid in the cycle mem_ack=1.
REQ-014 mem_ack  input  1  memory completion strobe.

Function
REQ-015 Access = EXMEM[72] | EXMEM[71]; if both bits are set, the access is a write.
REQ-016 FSM has two states, IDLE and WAIT.
REQ-017 IDLE, access, EXMEM[1:0]==0: next edge sets mem_req=1, mem_we=EXMEM[71], mem_addr=EXMEM[31:0], mem_wdata=EXMEM[63:32], clears wait counter, goes to WAIT; MemStall=1 this cycle.
REQ-018 IDLE, access, EXMEM[1:0]!=0: no request, MemStall=0, AlignErr=1 next cycle, MEMWB loads a bubble (all zeros).
REQ-019 IDLE, no access: MemStall=0; MEMWB loads {EXMEM[70:64], 32'b0, EXMEM[31:0]} each edge.
REQ-020 WAIT, mem_ack=1: MemStall=0; next edge loads MEMWB with {EXMEM[70:64], mem_rdata (0 for writes), EXMEM[31:0]}, mem_req=0, state IDLE.
REQ-021 WAIT, mem_ack=0: MemStall=1, mem_req/mem_we/mem_addr/mem_wdata held stable, counter increments, MEMWB loads a bubble.
REQ-022 WAIT, counter==TIMEOUT-1 and mem_ack=0: MemStall=0, next edge mem_req=0, state IDLE, BusErr=1 for one cycle, MEMWB loads a bubble.
REQ-023 mem_ack while IDLE is ignored.
REQ-024 Minimum load/store latency: one stall cycle (request issued at edge 1, ack in cycle 1, MEMWB valid after edge 2).
REQ-025 Exactly one request per instruction; a new EXMEM value arrives only after a cycle with MemStall=0, never reissuing a completed access.
REQ-026 Counter is 8 bits, saturating; it never wraps.

Reset
REQ-027 With reset=0 at a rising edge: state IDLE, MEMWB=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counter=0, AlignErr=0, BusErr=0.
REQ-028 While reset=0, MemStall=0, regardless of EXMEM.
REQ-029 Reset asserted in WAIT drops the request immediately at that edge; a late mem_ack is ignored.

Verification
REQ-030 ALU op, EXMEM={9'b001_0_00011, X, 32'h1234} -> MemStall=0, next edge MEMWB[31:0]=32'h1234, rd=3, dataMEMWB=32'h1234.
REQ-031 Load addr 32'h100, mem_ack in the first WAIT cycle with mem_rdata=32'hDEAD_BEEF -> exactly 1 stall cycle, MEMWB[63:32]=32'hDEAD_BEEF, dataMEMWB=32'hDEAD_BEEF.
REQ-032 Store addr 32'h8, data 32'h55, ack after 3 WAIT cycles -> mem_we=1, stable address/data for 3 cycles, 3 bubbles then MEMWB RegWrite=0.
REQ-033 Load addr 32'h102 -> no mem_req, AlignErr pulse one cycle, MEMWB=0.
REQ-034 Load with no ack, TIMEOUT=4 -> 4 stall cycles, BusErr pulse, mem_req=0, state IDLE.
REQ-035 reset=0 in the second WAIT cycle, then ack -> mem_req=0 after the edge, MEMWB=0, no load data captured.

Source files
------------

// File: rtl/pipe_mem_memwb.sv
// MEM stage with MEM/WB register: one data-memory request per access,
// waits for mem_ack with a timeout, flags misaligned or timed-out accesses.
// Ports: clk, reset (sync, active-low); EXMEM in, MEMWB out;
// dataEXMEM/dataMEMWB forwarding; MemStall, AlignErr, BusErr status;
// mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ack in.
module pipe_mem_memwb #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [72:0] EXMEM,
  output logic [70:0] MEMWB,
  output logic [31:0] dataEXMEM,
  output logic [31:0] dataMEMWB,
  output logic        MemStall,
  output logic        AlignErr,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t      state, state_d;
  logic [7:0]  cnt, cnt_d;
  logic        req_d, we_d;
  logic [31:0] addr_d, wdata_d;
  logic        align_d, bus_d;
  logic [70:0] memwb_d;
  logic        stall;
  logic        access, aligned;

  assign access  = EXMEM[72] | EXMEM[71];
  assign aligned = (EXMEM[1:0] == 2'b00);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    req_d   = mem_req;
    we_d    = mem_we;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    align_d = 1'b0;
    bus_d   = 1'b0;
    memwb_d = '0;
    stall   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (access && aligned) begin
          stall   = 1'b1;
          state_d = S_WAIT;
          req_d   = 1'b1;
          // MemWrite wins when both access bits are set
          we_d    = EXMEM[71];
          addr_d  = EXMEM[31:0];
          wdata_d = EXMEM[63:32];
          cnt_d   = '0;
        end else if (access) begin
          align_d = 1'b1;
        end else begin
          memwb_d = {EXMEM[70:64], 32'b0, EXMEM[31:0]};
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          memwb_d = {EXMEM[70:64],
                     mem_we ? 32'b0 : mem_rdata,
                     EXMEM[31:0]};
        end else if (cnt == TLAST) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          bus_d   = 1'b1;
        end else begin
          stall = 1'b1;
          if (cnt != 8'hFF) cnt_d = cnt + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      AlignErr  <= 1'b0;
      BusErr    <= 1'b0;
      MEMWB     <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      AlignErr  <= align_d;
      BusErr    <= bus_d;
      MEMWB     <= memwb_d;
    end
  end

  // Reset overrides any stall request so upstream is never frozen in reset
  assign MemStall  = reset & stall;
  assign dataEXMEM = EXMEM[31:0];
  assign dataMEMWB = MEMWB[69] ? MEMWB[63:32] : MEMWB[31:0];

endmodule
